// File: rtl/mmio_uart_hub_if.sv
// Request/response bundles between the core, the hub and the memory backends.
// DataMemoryWithMMIO adds a combinational MMIO read path (rd_inst) to the plain bundle.
interface DataMemory;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;

    modport master (output en, we, addr, wd, input rd, stall);
    modport slave  (input en, we, addr, wd, output rd, stall);
endinterface

interface DataMemoryWithMMIO;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] rd_inst;
    logic        stall;

    modport master (output en, we, addr, wd, input rd, rd_inst, stall);
    modport slave  (input en, we, addr, wd, output rd, rd_inst, stall);
endinterface

// File: rtl/mmio_uart_hub.sv
// Memory/MMIO hub: routes core requests to code BRAM or DDR2, and exposes a UART RX
// ring buffer, a TX byte FIFO drained into UartTx, and sticky overflow/drop status.
module mmio_uart_hub #(
    parameter logic [31:0] CODE_SECTION_SIZE = 32'h6c00,
    parameter int unsigned RX_DEPTH          = 512,
    parameter int unsigned TX_DEPTH          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_ready_i,
    input  logic [31:0]             data_i,
    DataMemoryWithMMIO.slave        m_data,
    output logic                    tx_start_o,
    output logic [7:0]              sdata_o,
    input  logic                    tx_busy_i,
    DataMemory.master               ddr2,
    DataMemory.master               instr_bram
);

    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned RxCw = RxAw + 1;
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned TxCw = TxAw + 1;

    localparam logic [31:0] AddrStatus  = 32'hFFFF_FFF0;
    localparam logic [31:0] AddrRxPop   = 32'hFFFF_FFF1;
    localparam logic [31:0] AddrRxCount = 32'hFFFF_FFF2;
    localparam logic [31:0] AddrTxPush  = 32'hFFFF_FFF4;
    localparam logic [31:0] AddrTxFree  = 32'hFFFF_FFF8;

    typedef enum logic [1:0] {StIdle, StWaitHi, StWaitLo} tx_state_e;

    // ---------------- region decode ----------------
    logic is_mmio, is_code;
    logic src_bram_q;

    assign is_mmio = m_data.addr[31];
    assign is_code = ~m_data.addr[31] & (m_data.addr < CODE_SECTION_SIZE);

    assign instr_bram.en   = m_data.en & is_code;
    assign instr_bram.we   = m_data.we;
    assign instr_bram.addr = m_data.addr;
    assign instr_bram.wd   = m_data.wd;
    assign ddr2.en         = m_data.en & ~is_mmio & ~is_code;
    assign ddr2.we         = m_data.we;
    assign ddr2.addr       = m_data.addr;
    assign ddr2.wd         = m_data.wd;

    assign m_data.stall = ddr2.stall | instr_bram.stall;
    assign m_data.rd    = src_bram_q ? instr_bram.rd : ddr2.rd;

    // Backend read data arrives a cycle later, so remember which one was addressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_bram_q <= 1'b0;
        end else if (m_data.en && !is_mmio) begin
            src_bram_q <= is_code;
        end
    end

    // ---------------- MMIO strobes ----------------
    logic mmio_rd, mmio_wr;
    logic status_wr, tx_push;

    assign mmio_rd   = m_data.en & ~m_data.we & is_mmio;
    assign mmio_wr   = m_data.en & m_data.we & is_mmio;
    assign status_wr = mmio_wr & (m_data.addr == AddrStatus);
    assign tx_push   = mmio_wr & (m_data.addr == AddrTxPush);

    // ---------------- RX ring ----------------
    logic [31:0]     rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0] rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
    logic [RxCw-1:0] rx_count_q, rx_count_d;
    logic            rx_overflow_q, rx_overflow_d;
    logic [15:0]     rx_total_q, rx_total_d;
    logic            rx_full, rx_pop;

    assign rx_full = (rx_count_q == RxCw'(RX_DEPTH));
    assign rx_pop  = mmio_rd & (m_data.addr == AddrRxPop) & (rx_count_q != '0);

    always_comb begin
        rx_head_d     = rx_head_q;
        rx_tail_d     = rx_tail_q;
        rx_count_d    = rx_count_q;
        rx_overflow_d = rx_overflow_q & ~status_wr;
        rx_total_d    = rx_total_q + 16'(data_ready_i);
        if (data_ready_i) begin
            rx_tail_d = rx_tail_q + RxAw'(1);
        end
        // A push into a full ring without a pop evicts the oldest word.
        if (rx_pop || (data_ready_i && rx_full)) begin
            rx_head_d = rx_head_q + RxAw'(1);
        end
        if (data_ready_i && rx_full && !rx_pop) begin
            rx_overflow_d = 1'b1;
        end
        if (data_ready_i && !rx_pop && !rx_full) begin
            rx_count_d = rx_count_q + RxCw'(1);
        end else if (rx_pop && !data_ready_i) begin
            rx_count_d = rx_count_q - RxCw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_head_q     <= '0;
            rx_tail_q     <= '0;
            rx_count_q    <= '0;
            rx_overflow_q <= 1'b0;
            rx_total_q    <= '0;
        end else begin
            rx_head_q     <= rx_head_d;
            rx_tail_q     <= rx_tail_d;
            rx_count_q    <= rx_count_d;
            rx_overflow_q <= rx_overflow_d;
            rx_total_q    <= rx_total_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_ready_i) begin
            rx_mem_q[rx_tail_q] <= data_i;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw-1:0] tx_head_q, tx_head_d, tx_tail_q, tx_tail_d;
    logic [TxCw-1:0] tx_count_q, tx_count_d;
    logic            tx_drop_q, tx_drop_d;
    logic            tx_full, tx_pop, tx_accept;
    tx_state_e       state_q;

    assign tx_full   = (tx_count_q == TxCw'(TX_DEPTH));
    assign tx_pop    = (state_q == StIdle) & (tx_count_q != '0) & ~tx_busy_i;
    assign tx_accept = tx_push & (~tx_full | tx_pop);

    always_comb begin
        tx_head_d  = tx_head_q;
        tx_tail_d  = tx_tail_q;
        tx_count_d = tx_count_q;
        tx_drop_d  = (tx_drop_q & ~status_wr) | (tx_push & ~tx_accept);
        if (tx_accept) begin
            tx_tail_d = tx_tail_q + TxAw'(1);
        end
        if (tx_pop) begin
            tx_head_d = tx_head_q + TxAw'(1);
        end
        if (tx_accept && !tx_pop) begin
            tx_count_d = tx_count_q + TxCw'(1);
        end else if (tx_pop && !tx_accept) begin
            tx_count_d = tx_count_q - TxCw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_head_q  <= '0;
            tx_tail_q  <= '0;
            tx_count_q <= '0;
            tx_drop_q  <= 1'b0;
        end else begin
            tx_head_q  <= tx_head_d;
            tx_tail_q  <= tx_tail_d;
            tx_count_q <= tx_count_d;
            tx_drop_q  <= tx_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_accept) begin
            tx_mem_q[tx_tail_q] <= m_data.wd[7:0];
        end
    end

    // ---------------- TX FSM ----------------
    logic       tx_start_q;
    logic [7:0] sdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_start_q <= 1'b0;
            sdata_q    <= '0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_pop) begin
                        sdata_q    <= tx_mem_q[tx_head_q];
                        tx_start_q <= 1'b1;
                        state_q    <= StWaitHi;
                    end
                end
                StWaitHi: if (tx_busy_i)  state_q <= StWaitLo;
                StWaitLo: if (!tx_busy_i) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign tx_start_o = tx_start_q;
    assign sdata_o    = sdata_q;

    // ---------------- MMIO read mux ----------------
    always_comb begin
        m_data.rd_inst = '0;
        case (m_data.addr)
            AddrStatus:  m_data.rd_inst = {rx_total_q, 14'b0, tx_drop_q, rx_overflow_q};
            AddrRxPop:   m_data.rd_inst = (rx_count_q != '0) ? rx_mem_q[rx_head_q] : '0;
            AddrRxCount: m_data.rd_inst = 32'(rx_count_q);
            AddrTxFree:  m_data.rd_inst = 32'(TX_DEPTH) - 32'(tx_count_q);
            default:     m_data.rd_inst = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Directed bench for mmio_uart_hub with small FIFOs (RX_DEPTH=4, TX_DEPTH=4).
module tb_mmio_uart_hub;

    localparam logic [31:0] AStat = 32'hFFFF_FFF0;
    localparam logic [31:0] APop  = 32'hFFFF_FFF1;
    localparam logic [31:0] ACnt  = 32'hFFFF_FFF2;
    localparam logic [31:0] APush = 32'hFFFF_FFF4;
    localparam logic [31:0] AFree = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ready = 1'b0;
    logic [31:0] data = '0;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_busy = 1'b0;

    DataMemoryWithMMIO m_if();
    DataMemory         ddr_if();
    DataMemory         bram_if();

    mmio_uart_hub #(
        .CODE_SECTION_SIZE (32'h6c00),
        .RX_DEPTH          (4),
        .TX_DEPTH          (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_ready_i (data_ready),
        .data_i       (data),
        .m_data       (m_if),
        .tx_start_o   (tx_start),
        .sdata_o      (sdata),
        .tx_busy_i    (tx_busy),
        .ddr2         (ddr_if),
        .instr_bram   (bram_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mmio(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input string name);
        @(negedge clk);
        m_if.en = 1'b1; m_if.we = we; m_if.addr = addr; m_if.wd = wd;
        #1;
        if (!we) check(name, m_if.rd_inst, exp);
        @(posedge clk);
        #1;
        m_if.en = 1'b0; m_if.we = 1'b0;
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input string name);
        vecs.push_back('{we, addr, wd, exp, name});
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) mmio(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp, vecs[i].name);
        vecs.delete();
    endtask

    task automatic strobe(input logic [31:0] w);
        @(negedge clk);
        data_ready = 1'b1; data = w;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          n_start;
        int          pend;
        int          left;
        logic [7:0]  cap[$];
        logic        seen;

        m_if.en = 1'b0; m_if.we = 1'b0; m_if.addr = '0; m_if.wd = '0;
        ddr_if.rd = 32'hD0D0_D0D0; ddr_if.stall = 1'b0;
        bram_if.rd = 32'hB0B0_B0B0; bram_if.stall = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("rst_sdata", {24'b0, sdata}, 32'd0);
        m_if.addr = AFree; #1;
        check("rst_tx_free", m_if.rd_inst, 32'd4);
        m_if.addr = AStat; #1;
        check("rst_status", m_if.rd_inst, 32'd0);
        rst = 1'b0;

        // Basic RX push/pop
        strobe(32'hA); strobe(32'hB); strobe(32'hC);
        add(0, ACnt, 0, 32'd3, "rx_count3");
        add(0, APop, 0, 32'hA, "rx_pop_a");
        add(0, APop, 0, 32'hB, "rx_pop_b");
        add(0, APop, 0, 32'hC, "rx_pop_c");
        add(0, APop, 0, 32'h0, "rx_pop_empty");
        add(0, ACnt, 0, 32'd0, "rx_count0");
        add(0, AStat, 0, 32'h0003_0000, "status_total3");
        add(0, 32'hFFFF_FFF3, 0, 32'h0, "unmapped");
        run_vecs();

        // RX overflow drops the oldest
        do_reset();
        for (int i = 1; i <= 5; i++) strobe(i);
        add(0, AStat, 0, 32'h0005_0001, "ovf_status");
        add(0, APop, 0, 32'd2, "ovf_pop2");
        add(0, APop, 0, 32'd3, "ovf_pop3");
        add(0, APop, 0, 32'd4, "ovf_pop4");
        add(0, APop, 0, 32'd5, "ovf_pop5");
        add(1, AStat, 32'hFFFF_FFFF, 0, "status_clear");
        add(0, AStat, 0, 32'h0005_0000, "ovf_cleared");
        run_vecs();

        // Full ring, simultaneous strobe and pop
        do_reset();
        for (int i = 0; i < 4; i++) strobe(32'h11 + i);
        @(negedge clk);
        data_ready = 1'b1; data = 32'h15;
        m_if.en = 1'b1; m_if.we = 1'b0; m_if.addr = APop;
        #1;
        check("full_pushpop_head", m_if.rd_inst, 32'h11);
        @(posedge clk); #1;
        data_ready = 1'b0; m_if.en = 1'b0;
        add(0, ACnt, 0, 32'd4, "full_pushpop_count");
        add(0, AStat, 0, 32'h0005_0000, "full_pushpop_noovf");
        add(0, APop, 0, 32'h12, "full_pushpop_next");
        run_vecs();

        // TX FIFO fill with busy held, then drain
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) add(1, APush, 32'h41 + i, 0, "tx_push");
        add(0, AFree, 0, 32'd0, "tx_free_full");
        add(0, AStat, 0, 32'h0000_0002, "tx_drop_set");
        run_vecs();
        @(negedge clk);
        tx_busy = 1'b0;
        n_start = 0; pend = 0; left = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_start) begin
                cap.push_back(sdata);
                n_start++;
                pend = 2;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    tx_busy = 1'b1;
                    left = 10;
                end
            end else if (left > 0) begin
                left--;
                if (left == 0) tx_busy = 1'b0;
            end
        end
        check("tx_start_count", n_start, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("tx_sdata_seq", (cap.size() > i) ? 32'(cap[i]) : 32'hFFFF_FFFF, 32'h41 + i);
        end
        add(0, AFree, 0, 32'd4, "tx_free_drained");
        run_vecs();

        // Region decode, read-source select and stall
        @(negedge clk);
        m_if.en = 1'b1; m_if.we = 1'b0; m_if.addr = 32'h10;
        #1;
        check("dec_bram_en", {31'b0, bram_if.en}, 32'd1);
        check("dec_ddr_en_off", {31'b0, ddr_if.en}, 32'd0);
        @(posedge clk); #1;
        m_if.en = 1'b0;
        check("rd_from_bram", m_if.rd, 32'hB0B0_B0B0);
        @(negedge clk);
        m_if.en = 1'b1; m_if.addr = 32'h8000;
        #1;
        check("dec_ddr_en", {31'b0, ddr_if.en}, 32'd1);
        check("dec_bram_en_off", {31'b0, bram_if.en}, 32'd0);
        check("ddr_addr_pass", ddr_if.addr, 32'h8000);
        @(posedge clk); #1;
        m_if.en = 1'b0;
        check("rd_from_ddr", m_if.rd, 32'hD0D0_D0D0);
        @(negedge clk);
        m_if.en = 1'b1; m_if.addr = 32'h6bff; #1;
        check("dec_bound_bram", {30'b0, bram_if.en, ddr_if.en}, 32'd2);
        m_if.addr = 32'h6c00; #1;
        check("dec_bound_ddr", {30'b0, bram_if.en, ddr_if.en}, 32'd1);
        m_if.addr = AStat; #1;
        check("dec_mmio_none", {30'b0, bram_if.en, ddr_if.en}, 32'd0);
        m_if.en = 1'b0;
        ddr_if.stall = 1'b1; #1;
        check("stall_ddr", {31'b0, m_if.stall}, 32'd1);
        ddr_if.stall = 1'b0; bram_if.stall = 1'b1; #1;
        check("stall_bram", {31'b0, m_if.stall}, 32'd1);
        bram_if.stall = 1'b0; #1;
        check("stall_none", {31'b0, m_if.stall}, 32'd0);

        // Asynchronous reset while waiting for busy to fall
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) add(1, APush, 32'h55 + i, 0, "tx_push_rst");
        run_vecs();
        @(negedge clk);
        tx_busy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        check("rst_mid_start_seen", {31'b0, seen}, 32'd1);
        check("rst_mid_sdata", {24'b0, sdata}, 32'h55);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        m_if.addr = AFree;
        #1;
        check("arst_tx_start", {31'b0, tx_start}, 32'd0);
        check("arst_sdata", {24'b0, sdata}, 32'd0);
        check("arst_tx_free", m_if.rd_inst, 32'd4);
        @(negedge clk);
        rst = 1'b0;
        tx_busy = 1'b0;
        n_start = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_start) n_start++;
        end
        check("arst_no_restart", n_start, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_hub.md
# mmio_uart_hub

Parametrised successor to the core's memory/MMIO hub. Decodes core data-memory requests into code-section BRAM, DDR2, or an MMIO window. The MMIO window holds a depth-parametrised UART RX ring buffer fed by the DMA path and a new TX byte FIFO drained autonomously into UartTx. Adds over the previous hub: a TX queue, overflow/drop status, and a registered read-source select.

## Interface
- CODE_SECTION_SIZE, 32'h6c00, word-address bound of the instruction BRAM; must match BRAM size.
- RX_DEPTH, 512, RX ring entries (32-bit); power of 2, ≥2.
- TX_DEPTH, 16, TX FIFO entries (8-bit); power of 2, ≥2.
- Count width: CW = $clog2(DEPTH)+1, computed per FIFO.
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high.
- data_ready  input  1  one-cycle strobe; data is a received word.
- data  input  32  received word.
- m_data  DataMemoryWithMMIO.slave  bundle  core request: en, we, addr, wd, rd, rd_inst, stall.
- tx_start  output  1  one-cycle send pulse to UartTx.
- sdata  output  8  byte to send; held stable from the tx_start cycle until the FSM returns to IDLE.
- tx_busy  input  1  UartTx busy.
- ddr2  DataMemory.master  bundle  DDR2 port.
- instr_bram  DataMemory.master  bundle  code-section BRAM port.

## Operation
- Region decode:
  - mmio = addr[31].
  - code = ~addr[31] & (addr < CODE_SECTION_SIZE).
  - instr_bram.en = en & code.
  - ddr2.en = en & ~addr[31] & ~code.
  - we, addr and wd are passed through to both backends.
- m_data.stall = ddr2.stall | instr_bram.stall. MMIO never stalls.
- Read source: register src_bram is loaded with `code` on every cycle where en & ~addr[31]. m_data.rd = src_bram ? instr_bram.rd : ddr2.rd.
- MMIO map (exact 32-bit address match; unmapped addresses read 0, writes ignored):
  - 0xFFFFFFF0 status, R/W:
    - bit0 rx_overflow (sticky).
    - bit1 tx_drop (sticky).
    - [31:16] rx_total, a wrapping count of data_ready strobes.
    - Any write clears bits 0 and 1 only.
  - 0xFFFFFFF1 RX pop, R: returns the head word and advances the head. When empty, returns 0 and nothing changes.
  - 0xFFFFFFF2 RX count, R: zero-extended rx_count.
  - 0xFFFFFFF4 TX push, W: enqueues wd[7:0].
  - 0xFFFFFFF8 TX free, R: TX_DEPTH − tx_count.
- RX ring:
  - A push on data_ready writes to the tail.
  - Full and push without pop: drop the oldest (head+1, tail+1, count unchanged) and set rx_overflow.
  - Full, push and pop in the same cycle: both proceed, count unchanged, no overflow.
  - Empty, push and pop in the same cycle: pop returns 0, push lands, count becomes 1.
- TX FIFO:
  - Push when full: discard and set tx_drop.
  - Push and FSM pop in the same cycle: both proceed.
- TX FSM:
  - IDLE: if tx_count > 0 & ~tx_busy, latch head into sdata, pop, pulse tx_start, go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. This covers UartTx raising busy one or more cycles after start.
  - WAIT_LO: wait for tx_busy=0, then go to IDLE.
- Pointers wrap modulo DEPTH. Counts are 0..DEPTH.

## Timing
- Reset values (asynchronous, immediate):
  - tx_start=0, sdata=0, FSM=IDLE.
  - All pointers and counts 0, stickies 0, rx_total 0, src_bram 0.
- m_data.rd_inst is combinational from the current-cycle addr and state. Pop and count side effects take effect at the next clock edge.
- A word strobed at edge N is visible in RX count and RX pop from cycle N+1.
- TX latency: a push in cycle N raises tx_start at the earliest in cycle N+1 (FSM in IDLE, tx_busy=0).
- Back-to-back bytes are separated by at least the full busy window plus 1 IDLE cycle.
- Reset mid-transmission: the FSM returns to IDLE and the queued bytes are lost. An in-flight UartTx frame is not aborted.

## Test plan
- Reset, then push 3 RX words 0xA,0xB,0xC: count reads 3; three pops return A,B,C; a 4th pop returns 0 and count stays 0.
- RX_DEPTH=4 with 5 strobes 1..5: pops return 2,3,4,5; status bit0=1 and [31:16]=5; a status write clears bit0.
- Full RX ring with a simultaneous strobe and pop: pop returns the head, count stays 4, bit0 stays 0.
- TX_DEPTH=4, push 0x41..0x45 with tx_busy held high: TX free=0 and status bit1=1. Release busy and model 10-cycle busy frames: sdata sequence is 41,42,43,44, with exactly one tx_start per byte.
- Read addr 0x10 (with CODE_SECTION_SIZE=0x6c00) then 0x8000: instr_bram.en and ddr2.en are asserted respectively, and m_data.rd follows instr_bram.rd then ddr2.rd; the stall of either backend propagates.
- Assert reset asynchronously during WAIT_LO: tx_start=0, FSM=IDLE, TX free=TX_DEPTH, with no edge required.
